lcd_bus_arbiter: RTL and testbench
==================================

# lcd_bus_arbiter

Shares the single Avalon-MM LCD_Controller slave between two instruction sources, e.g. the menu-text sequencer and a status/overlay writer. Each requester streams 9-bit LCD instructions (bit 8 = LCD `address`/RS, bits 7:0 = data) over a valid/ready handshake. Messages are never interleaved: a requester keeps the bus from its first beat through the beat it marks `last`. Requesters that have no burst in progress are served round-robin. The block sits between the requesters and the LCD_Controller slave and is the only Avalon master on that slave.

## Interface
- `GAP_CYCLES`, default 4: idle cycles inserted after every completed write, before the next beat may be accepted. Range 0..255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a beat.
- `req0_instr`  in  9  requester 0 instruction {rs, data[7:0]}.
- `req0_last`  in  1  this beat ends requester 0's message.
- `req0_ready`  out  1  beat accepted this cycle.
- `req1_valid`, `req1_instr`, `req1_last`, `req1_ready`: same as requester 0, for requester 1.
- `address`  out  1  Avalon address (= held instr bit 8).
- `chipselect`  out  1  equals `write`.
- `byteenable`  out  1  constant 1.
- `read`  out  1  constant 0.
- `write`  out  1  Avalon write strobe.
- `writedata`  out  8  held instr[7:0] while `write`=1, else 0.
- `waitrequest`  in  1  slave stall.
- `readdata`  in  8  unused.
- `response`  in  2  slave response, sampled when a write completes.
- `grant`  out  2  one-hot current owner; 0 when no owner.
- `busy`  out  1  state ≠ IDLE, or an owner lock is held.
- `err_count`  out  8  count of non-zero responses; saturates at 255.

## Operation
- The FSM has three states: IDLE, WRITE and GAP.
- **IDLE, no lock:**
  - Eligible requesters are those with `valid`=1.
  - If both are eligible, the requester not granted last wins.
  - After reset, requester 0 has priority.
  - The winner's `ready` is driven combinationally to 1 in the same cycle.
  - On `valid & ready`, the beat's instr and last flag are captured into a holding register, `grant` is set to the winner, and the FSM goes to WRITE.
- **IDLE, lock held:**
  - Only the owner is eligible. The other requester's `ready` stays 0 even if the owner's `valid`=0.
  - There is no timeout; the bus waits for the owner.
- **WRITE:**
  - `write`=`chipselect`=1, `address`=hold[8], `writedata`=hold[7:0].
  - Outputs hold steady while `waitrequest`=1.
  - The write completes on the rising edge where `waitrequest`=0.
  - On completion, `response` is sampled. If it is ≠ 0, `err_count` increments (saturating).
  - After completion, the FSM goes to GAP, or directly to IDLE if `GAP_CYCLES`=0.
- **GAP:**
  - A counter loads `GAP_CYCLES`-1 on entry and decrements each cycle.
  - When the counter reads 0, the FSM goes to IDLE.
- **Lock handling:**
  - The lock is set when a captured beat has last=0.
  - The lock is cleared when a beat with last=1 completes its write. At that point `grant` returns to 0 and the last-granted pointer updates.
- `ready` is 0 in WRITE and GAP. Requesters must hold `valid`, `instr` and `last` stable until accepted.

## Timing
- All outputs are 0 during reset, except `byteenable`=1. The state returns to IDLE, the lock clears, `err_count`=0, and the last-granted pointer points to requester 1.
- Reset asserted mid-WRITE drops `write` immediately (asynchronous). The beat is lost and is not retried.
- Acceptance to first `write` cycle: 1 cycle.
- Minimum beat period with zero wait states: 2 + `GAP_CYCLES` cycles.
- A single-beat message (last=1 on its first beat) takes no lock. Round-robin then applies on the next IDLE.
- A beat that completes with a non-zero `response` is still treated as done. The lock logic is unaffected.
- While a lock is held, round-robin state does not change.

## Test plan
1. **Single requester, `GAP_CYCLES`=4, no stall.**
   - Stimulus: req0 sends 17 beats (CLEAR_DISPLAY + 16 chars, last on beat 17).
   - Required: 17 writes, spaced 6 cycles apart, data in order; `grant`=01 throughout, then 00.
2. **Contention out of reset.**
   - Stimulus: both requesters are valid with 3-beat messages.
   - Required: all 3 req0 writes come first, then all 3 req1 writes; no interleave; `req1_ready` stays 0 until req0's last beat completes.
3. **Round-robin fairness.**
   - Stimulus: both requesters repeatedly send single-beat messages.
   - Required: writes alternate 0,1,0,1…
4. **Waitrequest stall.**
   - Stimulus: `waitrequest` held high for 5 cycles on beat 2.
   - Required: `write`, `address` and `writedata` are constant for 6 cycles; then GAP follows; no beat is dropped or duplicated.
5. **Error counting.**
   - Stimulus: `response`=2'b10 on 300 completions.
   - Required: `err_count` saturates at 255.
6. **Reset mid-message.**
   - Stimulus: `reset_n` pulsed low during WRITE of beat 5 of req1.
   - Required: `write` drops that cycle, the lock clears, and the next contention grants req0 first.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin, message-locked sharing of one Avalon-MM LCD slave between two instruction streams
module lcd_bus_arbiter #(
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [8:0] req0_instr,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [8:0] req1_instr,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       address,
  output logic       chipselect,
  output logic       byteenable,
  output logic       read,
  output logic       write,
  output logic [7:0] writedata,
  input  logic       waitrequest,
  input  logic [7:0] readdata,
  input  logic [1:0] response,
  output logic [1:0] grant,
  output logic       busy,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
  state_t state;
  logic [8:0] hold;
  logic [7:0] gap_cnt;
  logic hold_last, lock, last_gnt, sel, open, accept, sel_last;
  logic unused_rd;
  assign unused_rd = ^readdata;
  // while locked only the current owner may be picked; otherwise the one not served last wins a tie
  assign sel = lock ? grant[1] : (req0_valid & req1_valid) ? ~last_gnt : req1_valid;
  assign sel_last = sel ? req1_last : req0_last;
  assign open = reset_n & (state == IDLE);
  assign req0_ready = open & ~sel & req0_valid;
  assign req1_ready = open & sel & req1_valid;
  assign accept = req0_ready | req1_ready;
  assign write = state == WRITE;
  assign chipselect = write;
  assign address = hold[8];
  assign writedata = write ? hold[7:0] : '0;
  assign byteenable = 1'b1;
  assign read = 1'b0;
  assign busy = (state != IDLE) | lock;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      hold <= '0;
      hold_last <= 1'b0;
      lock <= 1'b0;
      last_gnt <= 1'b1;
      grant <= '0;
      gap_cnt <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          hold <= sel ? req1_instr : req0_instr;
          hold_last <= sel_last;
          lock <= lock | ~sel_last;
          grant <= sel ? 2'b10 : 2'b01;
          state <= WRITE;
        end
        WRITE: if (!waitrequest) begin
          if (response != 2'b00 && err_count != '1) err_count <= err_count + 8'd1;
          if (hold_last) begin
            lock <= 1'b0;
            grant <= '0;
            last_gnt <= grant[1];
          end
          gap_cnt <= 8'(GAP_CYCLES - 1);
          state <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed self-checking bench for lcd_bus_arbiter
module tb_lcd_bus_arbiter;
  logic clk = 0;
  logic reset_n = 0;
  logic req0_valid = 0, req0_last = 0, req1_valid = 0, req1_last = 0, waitrequest = 0;
  logic [8:0] req0_instr = '0;
  logic [8:0] req1_instr = '0;
  logic [7:0] readdata = '0;
  logic [1:0] response = '0;
  logic req0_ready, req1_ready, address, chipselect, byteenable, read, write, busy;
  logic [7:0] writedata, err_count;
  logic [1:0] grant;
  int n_checks = 0, n_errors = 0, cyc = 0, r1_first = -1, g_bad = 0;
  bit watch_g = 0;
  logic [8:0] wr_q[$];
  logic [1:0] wr_g[$];
  int wr_c[$];

  lcd_bus_arbiter #(.GAP_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_last(req1_last), .req1_ready(req1_ready),
    .address(address), .chipselect(chipselect), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata), .response(response),
    .grant(grant), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (watch_g && wr_q.size() > 0 && wr_q.size() < 17 && grant != 2'b01) g_bad++;
    if (req1_ready && r1_first < 0) r1_first = cyc;
    if (reset_n && write && !waitrequest) begin
      wr_q.push_back({address, writedata});
      wr_g.push_back(grant);
      wr_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input int r, input logic [8:0] ins, input logic lst);
    int n = 0;
    bit ok = 0;
    if (r == 0) begin req0_valid = 1; req0_instr = ins; req0_last = lst; end
    else begin req1_valid = 1; req1_instr = ins; req1_last = lst; end
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = (r == 0) ? req0_ready : req1_ready;
      n++;
    end
    check("accept", ok, 1);
    @(posedge clk); #1;
    if (r == 0) req0_valid = 0;
    else req1_valid = 0;
  endtask

  task automatic stream(input int r, input int n, input logic [8:0] base, input bit single);
    for (int i = 0; i < n; i++) put(r, base + 9'(i), single || i == n - 1);
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_g.delete();
    wr_c.delete();
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_write", write, 0);
    check("rst_cs", chipselect, 0);
    check("rst_be", byteenable, 1);
    check("rst_read", read, 0);
    check("rst_wdata", writedata, 0);
    check("rst_addr", address, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 0);
    @(posedge clk); #1;
    reset_n = 1;
    // single requester, 17-beat message
    watch_g = 1;
    for (int i = 0; i < 17; i++) put(0, i == 0 ? 9'h001 : 9'h140 + 9'(i), i == 16);
    settle();
    watch_g = 0;
    check("t1_count", wr_q.size(), 17);
    for (int i = 0; i < wr_q.size(); i++) begin
      check("t1_data", wr_q[i], i == 0 ? 9'h001 : 9'h140 + 9'(i));
      check("t1_grant", wr_g[i], 2'b01);
      if (i > 0) check("t1_spacing", wr_c[i] - wr_c[i-1], 6);
    end
    check("t1_grant_hold", g_bad, 0);
    check("t1_grant_end", grant, 0);
    check("t1_busy_end", busy, 0);
    // contention out of reset
    do_reset();
    clear_log();
    r1_first = -1;
    fork
      stream(0, 3, 9'h010, 0);
      stream(1, 3, 9'h120, 0);
    join
    settle();
    check("t2_count", wr_q.size(), 6);
    for (int i = 0; i < wr_q.size(); i++) begin
      check("t2_grant", wr_g[i], i < 3 ? 2'b01 : 2'b10);
      check("t2_data", wr_q[i], i < 3 ? 9'h010 + 9'(i) : 9'h120 + 9'(i - 3));
    end
    if (wr_c.size() >= 3) check("t2_r1_wait", r1_first > wr_c[2], 1);
    // round-robin with single-beat messages
    clear_log();
    fork
      stream(0, 4, 9'h030, 1);
      stream(1, 4, 9'h150, 1);
    join
    settle();
    check("t3_count", wr_q.size(), 8);
    for (int i = 0; i < wr_q.size(); i++) begin
      check("t3_grant", wr_g[i], i % 2 == 0 ? 2'b01 : 2'b10);
      check("t3_data", wr_q[i], i % 2 == 0 ? 9'h030 + 9'(i / 2) : 9'h150 + 9'(i / 2));
    end
    check("t3_busy_end", busy, 0);
    // waitrequest stall on beat 2
    clear_log();
    fork
      stream(0, 3, 9'h1a0, 0);
      begin
        int wt = 0;
        while (!(write && wr_q.size() == 1) && wt < 500) begin @(posedge clk); #1; wt++; end
        check("t4_stall_start", write, 1);
        waitrequest = 1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("t4_hold_wr", write, 1);
          check("t4_hold_data", {address, writedata}, 9'h1a1);
          @(posedge clk); #1;
          if (k == 4) waitrequest = 0;
        end
        @(negedge clk);
        check("t4_gap_wr", write, 0);
        check("t4_gap_busy", busy, 1);
      end
    join
    settle();
    check("t4_count", wr_q.size(), 3);
    for (int i = 0; i < wr_q.size(); i++) check("t4_data", wr_q[i], 9'h1a0 + 9'(i));
    if (wr_c.size() == 3) begin
      check("t4_stall_gap", wr_c[1] - wr_c[0], 11);
      check("t4_after_gap", wr_c[2] - wr_c[1], 6);
    end
    // error counting and saturation
    clear_log();
    check("t5_err_start", err_count, 0);
    response = 2'b10;
    stream(0, 5, 9'h040, 1);
    settle();
    check("t5_err_5", err_count, 5);
    stream(0, 295, 9'h040, 1);
    settle();
    check("t5_err_sat", err_count, 255);
    check("t5_count", wr_q.size(), 300);
    response = 2'b00;
    // reset during beat 5 of a req1 message
    clear_log();
    stream(1, 4, 9'h0b0, 0);
    put(1, 9'h0b4, 0);
    check("t6_in_write", write, 1);
    check("t6_lock_busy", busy, 1);
    #1 reset_n = 0;
    #1;
    check("t6_write_drop", write, 0);
    check("t6_cs_drop", chipselect, 0);
    check("t6_grant_clr", grant, 0);
    check("t6_busy_clr", busy, 0);
    check("t6_err_clr", err_count, 0);
    check("t6_beats", wr_q.size(), 4);
    @(posedge clk); #1;
    reset_n = 1;
    clear_log();
    fork
      put(0, 9'h0c0, 1);
      put(1, 9'h1c8, 1);
    join
    settle();
    check("t6_count", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("t6_first_grant", wr_g[0], 2'b01);
      check("t6_first_data", wr_q[0], 9'h0c0);
      check("t6_second_grant", wr_g[1], 2'b10);
      check("t6_second_data", wr_q[1], 9'h1c8);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
